// File: rtl/mini_core_mem_req_q.sv
// -----------------------------------------------------------------------------
// mini_core_mem_req_q
//   Request queue between the mini_core memory stage (Q103H) and the memory
//   fabric. Holds up to DEPTH legal requests in order. Each request's address
//   is decoded into a region (I_MEM / D_MEM) when the request is accepted.
//   Legal requests drain over a valid/ready link, and the number of reads in
//   flight is capped at MAX_RD_OUTST. Illegal requests are dropped and reported
//   as access faults.
//
// Ports
//   Clk, RstN         core clock, asynchronous active-low reset
//   ReqValidQ103H     in   core request valid
//   Core2MemReqQ103H  in   {WrData[31:0], Address[31:0], WrEn, RdEn, ByteEn[3:0]}
//   ReqReadyQ103H     out  queue can accept this cycle (depends on state only)
//   MemReqValid       out  head request presented to fabric
//   MemReq            out  head request
//   MemReqRegion      out  head region: 00 I_MEM, 01 D_MEM
//   MemReqReady       in   fabric accepts head
//   MemRspValid       in   one read response returned
//   RdOutstanding     out  reads issued minus responses received
//   FaultValid        out  one-cycle pulse: illegal request dropped
//   FaultAddr         out  address of the last dropped request
//   FaultCnt          out  saturating count of dropped requests
// -----------------------------------------------------------------------------
module mini_core_mem_req_q #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned MAX_RD_OUTST = 2
) (
    input  logic        Clk,
    input  logic        RstN,
    input  logic        ReqValidQ103H,
    input  logic [69:0] Core2MemReqQ103H,
    output logic        ReqReadyQ103H,
    output logic        MemReqValid,
    output logic [69:0] MemReq,
    output logic [1:0]  MemReqRegion,
    input  logic        MemReqReady,
    input  logic        MemRspValid,
    output logic [3:0]  RdOutstanding,
    output logic        FaultValid,
    output logic [31:0] FaultAddr,
    output logic [7:0]  FaultCnt
);

    localparam int unsigned PW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] wr_data;
        logic [31:0] address;
        logic        wr_en;
        logic        rd_en;
        logic [3:0]  byte_en;
    } req_t;

    typedef enum logic [1:0] {
        REGION_IMEM = 2'b00,
        REGION_DMEM = 2'b01
    } region_e;

    // Entry storage is intentionally not reset.
    req_t    req_mem    [DEPTH];
    region_e region_mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q,  count_d;
    logic [3:0]    rd_outst_q, rd_outst_d;
    logic          fault_valid_q, fault_valid_d;
    logic [31:0]   fault_addr_q,  fault_addr_d;
    logic [7:0]    fault_cnt_q,   fault_cnt_d;

    req_t    in_req;
    region_e in_region;
    logic    in_none;
    logic    in_illegal;
    logic    accept;
    logic    push;
    logic    pop;
    logic    empty;
    logic    head_rd_blocked;
    logic    rsp_eff;
    req_t    head;

    assign in_req = req_t'(Core2MemReqQ103H);

    // Region decode: bits [31:17] set means beyond D_MEM; bit 16 selects D_MEM.
    always_comb begin
        in_none    = !in_req.wr_en && !in_req.rd_en;
        in_region  = in_req.address[16] ? REGION_DMEM : REGION_IMEM;
        in_illegal = !in_none &&
                     ((in_req.wr_en && in_req.rd_en) || (in_req.address[31:17] != '0));
    end

    assign ReqReadyQ103H = (count_q < (PW+1)'(DEPTH));
    assign accept        = ReqValidQ103H && ReqReadyQ103H;
    assign push          = accept && !in_none && !in_illegal;

    assign empty           = (count_q == '0);
    assign head            = req_mem[rd_ptr_q];
    assign head_rd_blocked = head.rd_en && (rd_outst_q == 4'(MAX_RD_OUTST));
    assign MemReqValid     = !empty && !head_rd_blocked;
    assign MemReq          = head;
    assign MemReqRegion    = region_mem[rd_ptr_q];
    assign pop             = MemReqValid && MemReqReady;

    // A response with nothing outstanding is ignored.
    assign rsp_eff = MemRspValid && (rd_outst_q != '0);

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        rd_outst_d    = rd_outst_q;
        fault_valid_d = 1'b0;
        fault_addr_d  = fault_addr_q;
        fault_cnt_d   = fault_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase

        case ({pop && head.rd_en, rsp_eff})
            2'b10:   rd_outst_d = rd_outst_q + 4'd1;
            2'b01:   rd_outst_d = rd_outst_q - 4'd1;
            default: rd_outst_d = rd_outst_q;
        endcase

        if (accept && in_illegal) begin
            fault_valid_d = 1'b1;
            fault_addr_d  = in_req.address;
            if (fault_cnt_q != '1) begin
                fault_cnt_d = fault_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            rd_outst_q    <= '0;
            fault_valid_q <= 1'b0;
            fault_addr_q  <= '0;
            fault_cnt_q   <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            rd_outst_q    <= rd_outst_d;
            fault_valid_q <= fault_valid_d;
            fault_addr_q  <= fault_addr_d;
            fault_cnt_q   <= fault_cnt_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            req_mem[wr_ptr_q]    <= in_req;
            region_mem[wr_ptr_q] <= in_region;
        end
    end

    assign RdOutstanding = rd_outst_q;
    assign FaultValid    = fault_valid_q;
    assign FaultAddr     = fault_addr_q;
    assign FaultCnt      = fault_cnt_q;

endmodule
